alu4_arbiter: RTL and testbench
===============================

# alu4_arbiter

Shares one 4-bit ALU datapath (ADD, SUB, AND, OR, XOR, MUL; 8-bit result) between two independent requesters. Each requester presents an opcode and two 4-bit operands with a valid/ready handshake. The block arbitrates between them, captures the winner's operands, drives the ALU select and operands, and returns the registered 8-bit result tagged with the requester ID on a single shared result channel. It sits between the two client FSMs and the ALU datapath, and it also keeps a wrapping count of completed operations.

## Interface
Parameters:
- CNT_W, default 16: width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- r0_valid  in  1  requester 0 has an operation pending.
- r0_op  in  3  requester 0 opcode.
- r0_a, r0_b  in  4 each  requester 0 operands.
- r0_ready  out  1  requester 0 operation accepted this cycle.
- r1_valid, r1_op, r1_a, r1_b, r1_ready: same meaning for requester 1.
- res_valid  out  1  result channel holds a valid result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  result value.
- res_cout  out  1  adder carry-out for ADD/SUB; 0 otherwise.
- res_id  out  1  requester that issued the result.
- res_err  out  1  opcode was reserved (6 or 7).
- ops_done  out  CNT_W  completed-operation count, wraps to 0.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6–7 reserved.
- ADD: res_data[3:0] = a+b (mod 16); res_data[7:4] = four copies of bit 3; res_cout = carry out of bit 3.
- SUB: a + ~b + 1, with the same extension and carry rules. cout=1 means no borrow.
- AND, OR, XOR: the result is in res_data[3:0]; res_data[7:4]=0.
- MUL: unsigned a×b, full 8 bits.
- Reserved opcodes: res_data=0, res_cout=0, res_err=1. The operation still completes and still counts.
- FSM states:
  - IDLE: arbitrate. If any valid is high, assert ready for the winner only, latch op/a/b/id, then go to EXEC. If neither is valid, stay in IDLE.
  - EXEC: drive the ALU from the latched values and register res_data, res_cout, res_err and res_id, then go to RESP.
  - RESP: hold res_valid=1 with stable outputs. On res_valid&&res_ready, increment ops_done and go to IDLE.
- r0_ready and r1_ready are 0 outside IDLE and are never both 1.
- Arbitration: a pointer last_grant records the most recently granted ID. If only one requester is valid, it wins. If both are valid, the requester that is not last_grant wins. last_grant updates on each accept.
- A requester may drop valid before it is accepted; the block takes no action on an un-granted request.

## Timing
- Reset values:
  - state=IDLE.
  - r0_ready=r1_ready=0 while rst is high.
  - res_valid=0, res_data=0, res_cout=0, res_id=0, res_err=0.
  - ops_done=0; last_grant=1, so requester 0 wins the first contention.
- Accept in cycle N (valid&&ready) gives res_valid=1 from cycle N+2.
- Minimum spacing between accepts is 3 cycles with res_ready tied high: accept in cycle N, next accept possible in cycle N+3.
- ops_done increments in the cycle after the result handshake and wraps from 2^CNT_W−1 to 0.
- Backpressure: while res_ready is low in RESP, all result outputs hold and both ready outputs stay 0.
- rst asserted mid-operation: any in-flight operation is discarded with no result, all outputs return to reset values immediately, and ops_done clears.
- If a valid rises in the same cycle the state returns to IDLE, it is seen that cycle. The accept is combinational on the valid inputs in IDLE.

## Configuration
- ALU4_ARB_RR_EN defined: round-robin arbitration as described above.
- ALU4_ARB_RR_EN undefined: fixed priority, where requester 0 always wins contention. last_grant is not implemented, and requester 1 is granted only when r0_valid=0.

## Test plan
- Reset, then r0 issues ADD a=7, b=2 with res_ready=1. Expect r0_ready pulse, then 2 cycles later res_data=8'hF9, res_cout=0, res_id=0, res_err=0; ops_done=1.
- r1 issues SUB a=3, b=5. Expect res_data=8'hFE, res_cout=0. Then r1 issues MUL a=15, b=15. Expect res_data=8'hE1, res_cout=0.
- Both valid continuously, AND/OR opcodes, with the RR macro defined. Expect grants alternating 0,1,0,1 and an accept every 3 cycles. With the macro undefined, expect all grants to go to 0.
- Hold res_ready=0 for 5 cycles after XOR a=4'hA, b=4'h6. Expect res_valid held with res_data=8'h0C stable, no ready asserted, and the accept after release.
- Opcode 7 from r0. Expect res_err=1, res_data=0, and ops_done incremented.
- Assert rst during EXEC. Expect res_valid=0 and ops_done=0 at once, no result delivered, and the next request processed normally.

Source files
------------

// File: rtl/alu4_arbiter_if.sv
// Requester and result channels of alu4_arbiter; slave is the arbiter side, master the clients/consumer side.
// Both requester channels are valid/ready; the result channel holds until res_ready.
interface alu4_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             r0_valid;
  logic [2:0]       r0_op;
  logic [3:0]       r0_a;
  logic [3:0]       r0_b;
  logic             r0_ready;

  logic             r1_valid;
  logic [2:0]       r1_op;
  logic [3:0]       r1_a;
  logic [3:0]       r1_b;
  logic             r1_ready;

  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_cout;
  logic             res_id;
  logic             res_err;
  logic [CNT_W-1:0] ops_done;

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    output r1_valid, r1_op, r1_a, r1_b,
    output res_ready,
    input  r0_ready, r1_ready,
    input  res_valid, res_data, res_cout, res_id, res_err, ops_done
  );

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    input  r1_valid, r1_op, r1_a, r1_b,
    input  res_ready,
    output r0_ready, r1_ready,
    output res_valid, res_data, res_cout, res_id, res_err, ops_done
  );
endinterface

// File: rtl/alu4_arbiter.sv
// Two-requester arbiter over a shared 4-bit ALU; accept->res_valid is 2 cycles, accepts at most every 3 cycles.
// Result holds while res_ready is low and no request is accepted; ALU4_ARB_RR_EN selects round-robin over fixed priority.
module alu4_arbiter #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  alu4_arbiter_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } req_t;

  typedef struct packed {
    logic [7:0] data;
    logic       cout;
    logic       err;
    logic       id;
  } res_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d;
  res_t             res_q, res_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic       any_vld;
  logic       gnt_id;
  logic       accept;
  logic [4:0] sum5;
  logic [7:0] alu_data;
  logic       alu_cout;
  logic       alu_err;

`ifdef ALU4_ARB_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  // Grant is combinational on the valids so a request rising on the return to IDLE is taken that cycle.
  always_comb begin
    any_vld = bus.r0_valid | bus.r1_valid;
`ifdef ALU4_ARB_RR_EN
    if (bus.r0_valid && bus.r1_valid) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = ~bus.r0_valid;
    end
`else
    gnt_id = ~bus.r0_valid;
`endif
    accept = !rst && (state_q == IDLE) && any_vld;
  end

  assign bus.r0_ready = accept & ~gnt_id;
  assign bus.r1_ready = accept &  gnt_id;

  always_comb begin
    sum5     = '0;
    alu_data = '0;
    alu_cout = 1'b0;
    alu_err  = 1'b0;
    case (req_q.op)
      OP_ADD: begin
        sum5     = {1'b0, req_q.a} + {1'b0, req_q.b};
        alu_data = {{4{sum5[3]}}, sum5[3:0]};
        alu_cout = sum5[4];
      end
      OP_SUB: begin
        // Carry-out set means no borrow.
        sum5     = {1'b0, req_q.a} + {1'b0, ~req_q.b} + 5'd1;
        alu_data = {{4{sum5[3]}}, sum5[3:0]};
        alu_cout = sum5[4];
      end
      OP_AND:  alu_data = {4'h0, req_q.a & req_q.b};
      OP_OR:   alu_data = {4'h0, req_q.a | req_q.b};
      OP_XOR:  alu_data = {4'h0, req_q.a ^ req_q.b};
      OP_MUL:  alu_data = {4'h0, req_q.a} * {4'h0, req_q.b};
      default: alu_err  = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    res_d      = res_q;
    ops_done_d = ops_done_q;
`ifdef ALU4_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (gnt_id) begin
            req_d = '{id: 1'b1, op: bus.r1_op, a: bus.r1_a, b: bus.r1_b};
          end else begin
            req_d = '{id: 1'b0, op: bus.r0_op, a: bus.r0_a, b: bus.r0_b};
          end
`ifdef ALU4_ARB_RR_EN
          last_grant_d = gnt_id;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = '{data: alu_data, cout: alu_cout, err: alu_err, id: req_q.id};
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      res_q      <= '0;
      ops_done_q <= '0;
`ifdef ALU4_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      res_q      <= res_d;
      ops_done_q <= ops_done_d;
`ifdef ALU4_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.res_valid = (state_q == RESP);
  assign bus.res_data  = res_q.data;
  assign bus.res_cout  = res_q.cout;
  assign bus.res_id    = res_q.id;
  assign bus.res_err   = res_q.err;
  assign bus.ops_done  = ops_done_q;

  a_one_ready : assert property (@(posedge clk) !(bus.r0_ready && bus.r1_ready));
  a_ready_idle : assert property (@(posedge clk) disable iff (rst)
    (bus.r0_ready || bus.r1_ready) |-> (state_q == IDLE));
  a_res_hold : assert property (@(posedge clk) disable iff (rst)
    (bus.res_valid && !bus.res_ready) |=>
      (bus.res_valid && $stable(bus.res_data) && $stable(bus.res_id) && $stable(bus.res_err)));

endmodule

// File: tb/tb_alu4_arbiter.sv
// Directed bench for alu4_arbiter: vector table of single operations plus contention, backpressure and reset sequences.
// Grant expectations follow ALU4_ARB_RR_EN (alternating when defined, always requester 0 otherwise).
module tb_alu4_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_ops;

  alu4_arbiter_if #(.CNT_W(16)) bus ();

  alu4_arbiter #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] d;
    logic       c;
    logic       e;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic id, input logic v, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      bus.r1_valid = v; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b;
    end else begin
      bus.r0_valid = v; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b;
    end
  endtask

  task automatic do_op(input vec_t v);
    drive(v.id, 1'b1, v.op, v.a, v.b);
    #1;
    chk("ready_own", v.id ? bus.r1_ready : bus.r0_ready, 1);
    chk("ready_other", v.id ? bus.r0_ready : bus.r1_ready, 0);
    step();
    drive(v.id, 1'b0, 3'd0, 4'd0, 4'd0);
    chk("exec_no_valid", bus.res_valid, 0);
    step();
    chk("res_valid", bus.res_valid, 1);
    chk("res_data", bus.res_data, v.d);
    chk("res_cout", bus.res_cout, v.c);
    chk("res_err", bus.res_err, v.e);
    chk("res_id", bus.res_id, v.id);
    step();
    exp_ops++;
    chk("ops_done", bus.ops_done, exp_ops);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic prev_gid;
    logic gid;
    logic e_gid;
    int   n;

    total = 0; bad = 0; exp_ops = 0;
    vt[0]  = '{1'b0, 3'd0, 4'h7, 4'h2, 8'hF9, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 3'd1, 4'h3, 4'h5, 8'hFE, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 3'd5, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 3'd0, 4'h8, 4'h8, 8'h00, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 3'd1, 4'h5, 4'h3, 8'h02, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 3'd2, 4'hC, 4'hA, 8'h08, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 3'd3, 4'h9, 4'h4, 8'h0D, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 3'd4, 4'hF, 4'h5, 8'h0A, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 3'd7, 4'h9, 4'h9, 8'h00, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 3'd6, 4'h1, 4'h1, 8'h00, 1'b0, 1'b1};
    vt[10] = '{1'b0, 3'd0, 4'h7, 4'h7, 8'hFE, 1'b0, 1'b0};
    vt[11] = '{1'b1, 3'd5, 4'h3, 4'h4, 8'h0C, 1'b0, 1'b0};
    vt[12] = '{1'b1, 3'd1, 4'h4, 4'h4, 8'h00, 1'b1, 1'b0};

    rst = 1'b1;
    bus.res_ready = 1'b1;
    drive(1'b0, 1'b1, 3'd0, 4'd1, 4'd1);
    drive(1'b1, 1'b1, 3'd0, 4'd1, 4'd1);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_r0_ready", bus.r0_ready, 0);
    chk("rst_r1_ready", bus.r1_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_cout", bus.res_cout, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_res_err", bus.res_err, 0);
    chk("rst_ops_done", bus.ops_done, 0);
    drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      do_op(vt[i]);
    end

    // Contention: r0 AND F&3=03, r1 OR 8|4=0C, both held valid.
    drive(1'b0, 1'b1, 3'd2, 4'hF, 4'h3);
    drive(1'b1, 1'b1, 3'd3, 4'h8, 4'h4);
    #1;
    prev_gid = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(bus.r0_ready || bus.r1_ready) && n < 10) begin
        if (bus.res_valid) begin
          chk("cont_res_id", bus.res_id, prev_gid);
          chk("cont_res_data", bus.res_data, prev_gid ? 8'h0C : 8'h03);
        end
        step();
        n++;
      end
      chk("cont_grant_seen", bus.r0_ready | bus.r1_ready, 1);
      chk("cont_both_ready", bus.r0_ready & bus.r1_ready, 0);
      gid = bus.r1_ready;
`ifdef ALU4_ARB_RR_EN
      e_gid = g[0];
`else
      e_gid = 1'b0;
`endif
      chk("cont_grant_id", gid, e_gid);
      if (g > 0) chk("cont_grant_gap", n, 2);
      prev_gid = gid;
      step();
    end
    drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    step();
    chk("cont_last_data", bus.res_data, prev_gid ? 8'h0C : 8'h03);
    step();
    exp_ops += 4;
    chk("cont_ops_done", bus.ops_done, exp_ops);

    // Backpressure: XOR A^6=0C held for 5 cycles while r1 waits.
    drive(1'b0, 1'b1, 3'd4, 4'hA, 4'h6);
    #1;
    chk("bp_r0_ready", bus.r0_ready, 1);
    step();
    drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    drive(1'b1, 1'b1, 3'd0, 4'h1, 4'h1);
    bus.res_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_data", bus.res_data, 8'h0C);
      chk("bp_no_ready", bus.r0_ready | bus.r1_ready, 0);
      step();
    end
    chk("bp_ops_hold", bus.ops_done, exp_ops);
    bus.res_ready = 1'b1;
    step();
    exp_ops++;
    chk("bp_ops_done", bus.ops_done, exp_ops);
    chk("bp_r1_accept", bus.r1_ready, 1);
    step();
    drive(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    step();
    chk("bp_next_data", bus.res_data, 8'h02);
    chk("bp_next_id", bus.res_id, 1);
    step();
    exp_ops++;
    chk("bp_next_ops", bus.ops_done, exp_ops);

    // Reset while the operation sits in EXEC.
    drive(1'b0, 1'b1, 3'd0, 4'h1, 4'h1);
    #1;
    chk("mid_r0_ready", bus.r0_ready, 1);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_ops_done", bus.ops_done, 0);
    chk("mid_rst_r0_ready", bus.r0_ready, 0);
    drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    step();
    step();
    rst = 1'b0;
    exp_ops = 0;
    step();
    chk("post_rst_no_result", bus.res_valid, 0);
    chk("post_rst_ops_done", bus.ops_done, 0);
    do_op('{1'b0, 3'd0, 4'h2, 4'h3, 8'h05, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
